fetch_entry_queue: RTL



---
 rtl/fetch_entry_queue.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_entry_queue.sv
// rtl/fetch_entry_queue.sv - in-order elastic queue between the realigner and decode
// Optional zero-latency bypass when empty: define FETCH_ENTRY_QUEUE_BYPASS_EN.
module fetch_entry_queue #(
  parameter int unsigned ENTRY_W = 128,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] fetch_entry_i,
  input  logic               fetch_entry_valid_i,
  output logic               fetch_entry_ready_o,
  output logic [ENTRY_W-1:0] fetch_entry_o,
  output logic               fetch_entry_valid_o,
  input  logic               fetch_entry_ready_i,
  output logic [CNT_W-1:0]   occupancy_o,
  output logic               empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wptr_q, rptr_q;
  logic [PW-1:0]      occ;
  logic               full, empty;
  logic               push, pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty = (wptr_q == rptr_q);
  assign occ   = wptr_q - rptr_q;

  assign occupancy_o         = CNT_W'(occ);
  assign empty_o             = empty;
  assign fetch_entry_ready_o = !full && !flush_i;

`ifdef FETCH_ENTRY_QUEUE_BYPASS_EN
  logic bypass_hit;
  logic bypass_take;

  // An empty queue forwards the incoming entry straight to decode.
  assign bypass_hit          = empty && fetch_entry_valid_i && !flush_i;
  assign bypass_take         = bypass_hit && fetch_entry_ready_i;
  assign fetch_entry_valid_o = !empty || bypass_hit;
  assign fetch_entry_o       = empty ? fetch_entry_i : mem[rptr_q[AW-1:0]];
  assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i && !bypass_take;
  assign pop  = !empty && fetch_entry_ready_i && !flush_i;
`else
  assign fetch_entry_valid_o = !empty;
  assign fetch_entry_o       = mem[rptr_q[AW-1:0]];
  assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
  assign pop  = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage is left unreset; its contents only matter behind a valid pointer.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q[AW-1:0]] <= fetch_entry_i;
  end

endmodule
